// File: rtl/i3c_dat_fetch_if.sv
// DAT memory read port: request/grant handshake plus read-data return.
// The fetch unit is the master, the DAT memory (or its arbiter) the slave.
interface i3c_dat_fetch_if #(
    parameter int AddrW = 8
);
    logic             mem_req;
    logic [AddrW-1:0] mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/i3c_dat_fetch.sv
// Fetches one 64-bit DAT entry as two 32-bit reads (low word, then high word),
// flags reserved-bit violations and read timeouts, and holds the result for later stages.
module i3c_dat_fetch #(
    parameter  int DatDepth      = 128,
    parameter  int TimeoutCycles = 64,
    localparam int DatIdxW       = $clog2(DatDepth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fetch_req_i,
    input  logic [DatIdxW-1:0] fetch_idx_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_err_o,
    output logic               rsvd_err_o,
    output logic [63:0]        dat_entry_o,
    output logic [6:0]         static_addr_o,
    output logic [7:0]         dynamic_addr_o,
    output logic               is_i2c_o,
    i3c_dat_fetch_if.master    mem
);

    localparam int CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_LO  = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    function automatic logic rsvd_violation(input logic [63:0] entry);
        return (|entry[11:7]) | (|entry[25:24]) | (|entry[63:59]);
    endfunction

    state_e             r_state;
    state_e             w_state_next;
    logic [DatIdxW-1:0] r_idx;
    logic [63:0]        r_entry;
    logic [CntW-1:0]    r_cnt;
    logic               r_timeout_err;
    logic               r_rsvd_err;
    logic               w_timeout;
    logic               w_word_sel;
    logic               w_busy;
    logic               w_done;
    logic               w_mem_req;

    // Last permitted wait cycle: no rvalid here means the next state is Done.
    assign w_timeout = (r_cnt == CntW'(TimeoutCycles - 1));

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (fetch_req_i) w_state_next = ST_REQ_LO;
                else             w_state_next = ST_IDLE;
            end
            ST_REQ_LO: begin
                if (mem.mem_gnt) w_state_next = ST_WAIT_LO;
                else             w_state_next = ST_REQ_LO;
            end
            ST_WAIT_LO: begin
                if (mem.mem_rvalid) w_state_next = ST_REQ_HI;
                else if (w_timeout) w_state_next = ST_DONE;
                else                w_state_next = ST_WAIT_LO;
            end
            ST_REQ_HI: begin
                if (mem.mem_gnt) w_state_next = ST_WAIT_HI;
                else             w_state_next = ST_REQ_HI;
            end
            ST_WAIT_HI: begin
                if (mem.mem_rvalid || w_timeout) w_state_next = ST_DONE;
                else                             w_state_next = ST_WAIT_HI;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_mem_req  = 1'b0;
        w_word_sel = 1'b0;
        case (r_state)
            ST_IDLE:    w_busy = 1'b0;
            ST_REQ_LO:  begin w_busy = 1'b1; w_mem_req = 1'b1; end
            ST_WAIT_LO: w_busy = 1'b1;
            ST_REQ_HI:  begin w_busy = 1'b1; w_mem_req = 1'b1; w_word_sel = 1'b1; end
            ST_WAIT_HI: begin w_busy = 1'b1; w_word_sel = 1'b1; end
            ST_DONE:    w_done = 1'b1;
            default:    w_busy = 1'b0;
        endcase
    end

    // Index, assembled entry, wait counter and error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx         <= '0;
            r_entry       <= 64'd0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_rsvd_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_req_i) begin
                        r_idx         <= fetch_idx_i;
                        r_timeout_err <= 1'b0;
                        r_rsvd_err    <= 1'b0;
                    end
                end
                ST_REQ_LO, ST_REQ_HI: begin
                    if (mem.mem_gnt) r_cnt <= '0;
                end
                ST_WAIT_LO: begin
                    if (mem.mem_rvalid)  r_entry[31:0] <= mem.mem_rdata;
                    else if (w_timeout)  r_timeout_err <= 1'b1;
                    else                 r_cnt         <= r_cnt + CntW'(1);
                end
                ST_WAIT_HI: begin
                    // Reserved bits are judged only on a fully assembled entry.
                    if (mem.mem_rvalid) begin
                        r_entry[63:32] <= mem.mem_rdata;
                        r_rsvd_err     <= rsvd_violation({mem.mem_rdata, r_entry[31:0]});
                    end else if (w_timeout) begin
                        r_timeout_err  <= 1'b1;
                    end else begin
                        r_cnt          <= r_cnt + CntW'(1);
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign busy_o         = w_busy;
    assign done_o         = w_done;
    assign timeout_err_o  = r_timeout_err;
    assign rsvd_err_o     = r_rsvd_err;
    assign dat_entry_o    = r_entry;
    assign static_addr_o  = r_entry[6:0];
    assign dynamic_addr_o = r_entry[23:16];
    assign is_i2c_o       = r_entry[31];
    assign mem.mem_req    = w_mem_req;
    assign mem.mem_addr   = {r_idx, w_word_sel};

endmodule

// File: tb/tb_i3c_dat_fetch.sv
// Directed bench for i3c_dat_fetch: table of full fetches plus hand sequences
// for timeout, late/stray rvalid and mid-operation reset.
module tb_i3c_dat_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_req_i;
    logic [6:0]  fetch_idx_i;
    logic        busy_o, done_o, timeout_err_o, rsvd_err_o, is_i2c_o;
    logic [63:0] dat_entry_o;
    logic [6:0]  static_addr_o;
    logic [7:0]  dynamic_addr_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int g_pulse = -1;

    i3c_dat_fetch_if #(.AddrW(8)) mem_if ();

    i3c_dat_fetch #(.DatDepth(128), .TimeoutCycles(64)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fetch_req_i    (fetch_req_i),
        .fetch_idx_i    (fetch_idx_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_err_o  (timeout_err_o),
        .rsvd_err_o     (rsvd_err_o),
        .dat_entry_o    (dat_entry_o),
        .static_addr_o  (static_addr_o),
        .dynamic_addr_o (dynamic_addr_o),
        .is_i2c_o       (is_i2c_o),
        .mem            (mem_if)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0]  idx;
        logic [31:0] lo;
        logic [31:0] hi;
        int          gdly;
        int          pulse;
        logic [63:0] exp_entry;
        logic [6:0]  exp_static;
        logic [7:0]  exp_dyn;
        logic        exp_i2c;
        logic        exp_rsvd;
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (cyc == g_pulse) begin
            fetch_req_i = 1'b1;
            fetch_idx_i = 7'd7;
        end else begin
            fetch_req_i = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  d;
        bit  found;
        g_pulse     = v.pulse;
        cyc         = 0;
        fetch_req_i = 1'b1;
        fetch_idx_i = v.idx;
        tick();
        for (int w = 0; w < 2; w++) begin
            d = (w == 0) ? v.gdly : 0;
            for (int k = 0; k <= d; k++) begin
                check("mem_req", {63'd0, mem_if.mem_req}, 64'd1);
                check("mem_addr", {56'd0, mem_if.mem_addr}, {56'd0, v.idx, w[0]});
                mem_if.mem_gnt = (k == d);
                tick();
            end
            mem_if.mem_gnt    = 1'b0;
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = (w == 0) ? v.lo : v.hi;
            tick();
            mem_if.mem_rvalid = 1'b0;
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (done_o) found = 1'b1;
            else        tick();
        end
        check("done_seen", {63'd0, found}, 64'd1);
        check("done_cycle", 64'(cyc), 64'(v.exp_done));
        check("entry", dat_entry_o, v.exp_entry);
        check("static_addr", {57'd0, static_addr_o}, {57'd0, v.exp_static});
        check("dynamic_addr", {56'd0, dynamic_addr_o}, {56'd0, v.exp_dyn});
        check("is_i2c", {63'd0, is_i2c_o}, {63'd0, v.exp_i2c});
        check("rsvd_err", {63'd0, rsvd_err_o}, {63'd0, v.exp_rsvd});
        check("timeout_err", {63'd0, timeout_err_o}, 64'd0);
        check("busy_at_done", {63'd0, busy_o}, 64'd0);
        tick();
        check("done_one_cycle", {63'd0, done_o}, 64'd0);
        check("idle_busy", {63'd0, busy_o}, 64'd0);
        check("idle_req", {63'd0, mem_if.mem_req}, 64'd0);
        g_pulse = -1;
    endtask

    initial begin
        bit found;
        vecs[0] = '{7'd5,  32'h00A5_1032, 32'h0012_3456, 0, -1, 64'h0012_3456_00A5_1032, 7'h32, 8'hA5, 1'b0, 1'b0, 5};
        vecs[1] = '{7'd5,  32'h00A5_1032, 32'h0012_3456, 3, -1, 64'h0012_3456_00A5_1032, 7'h32, 8'hA5, 1'b0, 1'b0, 8};
        vecs[2] = '{7'd9,  32'h0000_0F80, 32'h0000_0000, 0, -1, 64'h0000_0000_0000_0F80, 7'h00, 8'h00, 1'b0, 1'b1, 5};
        vecs[3] = '{7'h7F, 32'h0000_0000, 32'hF800_0000, 0, -1, 64'hF800_0000_0000_0000, 7'h00, 8'h00, 1'b0, 1'b1, 5};
        vecs[4] = '{7'd3,  32'h8055_0042, 32'h0000_0001, 0,  2, 64'h0000_0001_8055_0042, 7'h42, 8'h55, 1'b1, 1'b0, 5};
        vecs[5] = '{7'd1,  32'h0200_0000, 32'h0000_0000, 1, -1, 64'h0000_0000_0200_0000, 7'h00, 8'h00, 1'b0, 1'b1, 6};
        vecs[6] = '{7'd2,  32'h7CFF_F07F, 32'h07FF_FFFF, 0,  5, 64'h07FF_FFFF_7CFF_F07F, 7'h7F, 8'hFF, 1'b0, 1'b0, 5};

        rst_i             = 1'b1;
        fetch_req_i       = 1'b0;
        fetch_idx_i       = 7'd0;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = 32'd0;
        tick();
        tick();
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_errs", {62'd0, timeout_err_o, rsvd_err_o}, 64'd0);
        check("rst_entry", dat_entry_o, 64'd0);
        check("rst_req", {63'd0, mem_if.mem_req}, 64'd0);
        check("rst_addr", {56'd0, mem_if.mem_addr}, 64'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Timeout on the low word, then a late rvalid that must be ignored.
        cyc         = 0;
        fetch_req_i = 1'b1;
        fetch_idx_i = 7'd4;
        tick();
        check("to_addr", {56'd0, mem_if.mem_addr}, 64'd8);
        mem_if.mem_gnt = 1'b1;
        tick();
        mem_if.mem_gnt = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (done_o) found = 1'b1;
            else        tick();
        end
        check("to_done_seen", {63'd0, found}, 64'd1);
        check("to_done_cycle", 64'(cyc), 64'd66);
        check("to_timeout_err", {63'd0, timeout_err_o}, 64'd1);
        check("to_busy", {63'd0, busy_o}, 64'd0);
        tick();
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_if.mem_rvalid = 1'b0;
        check("late_rv_done", {63'd0, done_o}, 64'd0);
        check("late_rv_busy", {63'd0, busy_o}, 64'd0);
        check("late_rv_req", {63'd0, mem_if.mem_req}, 64'd0);
        check("late_rv_err_hold", {63'd0, timeout_err_o}, 64'd1);
        tick();

        // Reset while waiting for the high word.
        cyc         = 0;
        fetch_req_i = 1'b1;
        fetch_idx_i = 7'd6;
        tick();
        mem_if.mem_gnt = 1'b1;
        tick();
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h1111_2222;
        tick();
        mem_if.mem_rvalid = 1'b0;
        check("rst_mid_addr_hi", {56'd0, mem_if.mem_addr}, 64'd13);
        mem_if.mem_gnt = 1'b1;
        tick();
        mem_if.mem_gnt = 1'b0;
        check("rst_mid_in_wait", {63'd0, busy_o}, 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_mid_req", {63'd0, mem_if.mem_req}, 64'd0);
        check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
        check("rst_mid_done", {63'd0, done_o}, 64'd0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_if.mem_rvalid = 1'b0;
        check("stray_rv_done", {63'd0, done_o}, 64'd0);
        check("stray_rv_busy", {63'd0, busy_o}, 64'd0);
        check("stray_rv_entry", dat_entry_o, 64'd0);
        tick();
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
